// File: rtl/seg_display_scheduler_if.sv
// Display source bus between the CPU core side and the display scheduler.
//   master : CPU/board side, drives the display sources, button and half select
//   slave  : scheduler side, returns the multiplexer data, scan clock and status
//   pc, reg_val     32-bit display sources
//   sys_valid/val   one-cycle syscall output strobe and its value
//   mode_btn        raw mode push button
//   half_sel        0 = low half, 1 = high half of the selected source
//   disp_data       16-bit value for the segment multiplexer
//   scan_clk        digit-scan clock
//   mode            0 PC, 1 REG, 2 SYS_LAST
//   sys_active      syscall override in progress
interface seg_display_scheduler_if;
  logic [31:0] pc;
  logic [31:0] reg_val;
  logic        sys_valid;
  logic [31:0] sys_val;
  logic        mode_btn;
  logic        half_sel;
  logic [15:0] disp_data;
  logic        scan_clk;
  logic [1:0]  mode;
  logic        sys_active;

  modport master (
    output pc, reg_val, sys_valid, sys_val, mode_btn, half_sel,
    input  disp_data, scan_clk, mode, sys_active
  );

  modport slave (
    input  pc, reg_val, sys_valid, sys_val, mode_btn, half_sel,
    output disp_data, scan_clk, mode, sys_active
  );
endinterface

// File: rtl/seg_display_scheduler.sv
// Shares the 4-digit 7-segment display between the PC, a selected register
// and timed syscall output, and generates the digit-scan clock.
//   clk    board clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seg_display_scheduler_if.slave (sources in, display data/status out)
//
// state  | meaning
// S_IDLE | display follows mode (PC, REG or last syscall value)
// S_HOLD | syscall value overrides the display for HOLD_TICKS scan ticks
//
// mode   | meaning
// M_PC   | show program counter
// M_REG  | show selected register
// M_SYS  | show last syscall value
module seg_display_scheduler #(
  parameter int PRESCALE   = 50000,
  parameter int HOLD_TICKS = 200,
  parameter int DEBOUNCE   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg_display_scheduler_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);

  typedef enum logic {S_IDLE, S_HOLD} ovr_t;
  typedef enum logic [1:0] {M_PC = 2'd0, M_REG = 2'd1, M_SYS = 2'd2} mode_t;

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          scan_q;

  logic [1:0]    btn_sync;
  logic          btn_s;
  logic          db_cand;
  logic          db_stable;
  logic [DW-1:0] db_cnt;
  logic [DW-1:0] db_cnt_n;
  logic          db_settle;
  logic          db_rise;

  ovr_t          state_q, state_d;
  mode_t         mode_q, mode_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [31:0]   latch_q, latch_d;
  logic [31:0]   src;
  logic [15:0]   disp_q, disp_d;
  logic          active_q;

  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      scan_q  <= 1'b0;
    end else if (tick) begin
      pre_cnt <= '0;
      scan_q  <= ~scan_q;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign btn_s = btn_sync[1];

  // A sample that differs from the candidate counts as the first of a new run.
  always_comb begin
    if (btn_s != db_cand)
      db_cnt_n = DW'(1);
    else if (db_cnt == DW'(DEBOUNCE))
      db_cnt_n = db_cnt;
    else
      db_cnt_n = db_cnt + 1'b1;
    db_settle = (db_cnt_n == DW'(DEBOUNCE));
    db_rise   = tick && db_settle && btn_s && !db_stable;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync  <= 2'b00;
      db_cand   <= 1'b0;
      db_cnt    <= '0;
      db_stable <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], bus.mode_btn};
      if (tick) begin
        db_cand <= btn_s;
        db_cnt  <= db_cnt_n;
        if (db_settle) db_stable <= btn_s;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    latch_d = latch_q;
    mode_d  = mode_q;

    if (bus.sys_valid) begin
      latch_d = bus.sys_val;
      hold_d  = HW'(HOLD_TICKS);
      state_d = S_HOLD;
    end else if (state_q == S_HOLD && tick) begin
      hold_d = hold_q - 1'b1;
      if (hold_q == HW'(1)) state_d = S_IDLE;
    end

    if (db_rise) begin
      case (mode_q)
        M_PC:    mode_d = M_REG;
        M_REG:   mode_d = M_SYS;
        default: mode_d = M_PC;
      endcase
    end

    // Select on the next override state so the display leaves the syscall
    // value on the same edge that sys_active falls.
    if (state_d == S_HOLD) begin
      src = latch_d;
    end else begin
      case (mode_q)
        M_PC:    src = bus.pc;
        M_REG:   src = bus.reg_val;
        default: src = latch_d;
      endcase
    end
    disp_d = bus.half_sel ? src[31:16] : src[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= M_PC;
      hold_q   <= '0;
      latch_q  <= '0;
      disp_q   <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      hold_q   <= hold_d;
      latch_q  <= latch_d;
      active_q <= (state_d == S_HOLD);
      if (tick) disp_q <= disp_d;
    end
  end

  assign bus.disp_data  = disp_q;
  assign bus.scan_clk   = scan_q;
  assign bus.mode       = mode_q;
  assign bus.sys_active = active_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
module tb_seg_display_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_display_scheduler_if bus();

  seg_display_scheduler #(.PRESCALE(4), .HOLD_TICKS(3), .DEBOUNCE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int ref_cnt;

  // Independent tick timing reference: tick is the cycle with count 3.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_cnt <= 0;
    else        ref_cnt <= (ref_cnt == 3) ? 0 : ref_cnt + 1;
  end

  typedef struct {
    logic [31:0] pc;
    logic        half;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next tick edge, optionally pulsing sys_valid
  // in the tick cycle itself.
  task automatic tick_p(input bit pulse, input logic [31:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (ref_cnt != 3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no tick within %0d cycles required 4", n);
    end
    if (pulse) begin
      bus.sys_valid = 1'b1;
      bus.sys_val   = v;
    end
    @(posedge clk);
    #1;
    bus.sys_valid = 1'b0;
  endtask

  task automatic tick();
    tick_p(1'b0, 32'h0);
  endtask

  task automatic press();
    bus.mode_btn = 1'b1;
    tick();
    tick();
    bus.mode_btn = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_off_tick(input logic [31:0] v);
    @(negedge clk);
    bus.sys_valid = 1'b1;
    bus.sys_val   = v;
    @(negedge clk);
    bus.sys_valid = 1'b0;
  endtask

  initial begin
    bus.pc = 32'h0040_1234;
    bus.reg_val = 32'h0;
    bus.sys_valid = 1'b0;
    bus.sys_val = 32'h0;
    bus.mode_btn = 1'b0;
    bus.half_sel = 1'b0;

    vt[0] = '{32'h0040_1234, 1'b0, 16'h1234};
    vt[1] = '{32'h0040_1234, 1'b1, 16'h0040};
    vt[2] = '{32'hCAFE_F00D, 1'b0, 16'hF00D};
    vt[3] = '{32'hCAFE_F00D, 1'b1, 16'hCAFE};

    #1;
    chk("rst_disp", bus.disp_data, 0);
    chk("rst_scan", bus.scan_clk, 0);
    chk("rst_mode", bus.mode, 0);
    chk("rst_active", bus.sys_active, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Test 1: first tick, scan period of 4 clocks
    tick();
    chk("t1_disp", bus.disp_data, 16'h1234);
    chk("t1_scan_first", bus.scan_clk, 1);
    chk("t1_mode", bus.mode, 0);
    chk("t1_active", bus.sys_active, 0);
    bus.pc = 32'h0040_5678;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_scan_hold", bus.scan_clk, 1);
    chk("t1_disp_hold", bus.disp_data, 16'h1234);
    @(posedge clk);
    #1;
    chk("t1_scan_toggle", bus.scan_clk, 0);
    chk("t1_disp_new", bus.disp_data, 16'h5678);

    for (int i = 0; i < 4; i++) begin
      bus.pc = vt[i].pc;
      bus.half_sel = vt[i].half;
      tick();
      chk($sformatf("vec%0d_disp", i), bus.disp_data, vt[i].exp);
    end

    // Test 2: syscall override, HOLD_TICKS=3
    bus.pc = 32'h0040_1234;
    bus.half_sel = 1'b1;
    pulse_off_tick(32'hDEAD_BEEF);
    chk("t2_active_next", bus.sys_active, 1);
    tick();
    chk("t2_disp_sys", bus.disp_data, 16'hDEAD);
    tick();
    chk("t2_active_t2", bus.sys_active, 1);
    chk("t2_disp_t2", bus.disp_data, 16'hDEAD);
    tick();
    chk("t2_active_end", bus.sys_active, 0);
    chk("t2_disp_pc", bus.disp_data, 16'h0040);

    // Test 3: debounce
    bus.half_sel = 1'b0;
    bus.reg_val = 32'h0000_00FF;
    bus.mode_btn = 1'b1;
    tick();
    chk("t3_mode_one_sample", bus.mode, 0);
    tick();
    chk("t3_mode_step", bus.mode, 1);
    bus.mode_btn = 1'b0;
    tick();
    tick();
    tick();
    chk("t3_disp_reg", bus.disp_data, 16'h00FF);
    bus.mode_btn = 1'b1;
    tick();
    bus.mode_btn = 1'b0;
    tick();
    tick();
    tick();
    chk("t3_glitch_mode", bus.mode, 1);

    // Test 4: mode cycling
    press();
    chk("t4_mode2", bus.mode, 2);
    chk("t4_disp_last_sys", bus.disp_data, 16'hBEEF);
    press();
    chk("t4_mode0", bus.mode, 0);
    chk("t4_disp_pc", bus.disp_data, 16'h1234);
    press();
    chk("t4_seq1", bus.mode, 1);
    press();
    chk("t4_seq2", bus.mode, 2);
    press();
    chk("t4_seq0", bus.mode, 0);

    // Test 5: reload on a tick with counter at 1
    pulse_off_tick(32'h1111_2222);
    tick();
    tick();
    chk("t5_disp_first", bus.disp_data, 16'h2222);
    tick_p(1'b1, 32'h3333_4444);
    chk("t5_active_reload", bus.sys_active, 1);
    chk("t5_disp_new", bus.disp_data, 16'h4444);
    tick();
    tick();
    chk("t5_active_2", bus.sys_active, 1);
    chk("t5_disp_2", bus.disp_data, 16'h4444);
    tick();
    chk("t5_active_end", bus.sys_active, 0);
    chk("t5_disp_pc", bus.disp_data, 16'h1234);

    // Test 6: asynchronous reset mid-HOLD
    press();
    pulse_off_tick(32'hABCD_0123);
    tick();
    chk("t6_pre_disp", bus.disp_data, 16'h0123);
    chk("t6_pre_mode", bus.mode, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_disp", bus.disp_data, 0);
    chk("t6_rst_mode", bus.mode, 0);
    chk("t6_rst_active", bus.sys_active, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_scan", bus.scan_clk, 1);
    chk("t6_disp_pc", bus.disp_data, 16'h1234);
    chk("t6_mode", bus.mode, 0);
    chk("t6_active", bus.sys_active, 0);
    press();
    press();
    chk("t6_mode2", bus.mode, 2);
    chk("t6_latch_cleared", bus.disp_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
